// File: rtl/rom_loader.sv
// Boot loader for the instruction RAM: takes a header/payload/checksum byte stream,
// packs big-endian words into the RAM write port and releases the core on a valid image.
//
// state | meaning
// HDR0  | waiting for count[15:8]
// HDR1  | waiting for count[7:0]; routes to DATA, CHECK or ERROR
// DATA  | payload bytes, one RAM write per four bytes
// CHECK | waiting for checksum byte
// DONE  | image verified, core released
// ERROR | oversize count or bad checksum, core held
module rom_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          MAX_WORDS  = 1024,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [31:0]           mem_write_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHECK, DONE, ERROR} state_t;

  localparam logic [16:0] MAX_COUNT = 17'(MAX_WORDS);

  state_t      state, state_next;
  logic [7:0]  count_hi;
  logic [15:0] count;
  logic [1:0]  byte_idx;
  logic [23:0] word_acc;
  logic [7:0]  checksum;

  logic        take;
  logic [15:0] hdr_count;
  logic        word_last;
  logic        image_last;

  assign take       = byte_valid && byte_ready;
  assign hdr_count  = {count_hi, byte_data};
  assign word_last  = (byte_idx == 2'd3);
  assign image_last = ((words_loaded + 16'd1) == count);

  assign load_done  = (state == DONE);
  assign load_error = (state == ERROR);
  assign cpu_hold   = (state != DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= HDR0;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (take) begin
      case (state)
        HDR0:  state_next = HDR1;
        HDR1: begin
          if (hdr_count == 16'd0)                   state_next = CHECK;
          else if ({1'b0, hdr_count} > MAX_COUNT)   state_next = ERROR;
          else                                      state_next = DATA;
        end
        DATA:  if (word_last && image_last) state_next = CHECK;
        CHECK: state_next = (byte_data == checksum) ? DONE : ERROR;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      byte_ready       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_write_addr   <= ADDR_WIDTH'(BASE_ADDR);
      mem_write_data   <= 32'd0;
      words_loaded     <= 16'd0;
      count_hi         <= 8'd0;
      count            <= 16'd0;
      byte_idx         <= 2'd0;
      word_acc         <= 24'd0;
      checksum         <= 8'd0;
    end else begin
      mem_write_enable <= 1'b0;
      byte_ready       <= (state_next == HDR0) || (state_next == HDR1) ||
                          (state_next == DATA) || (state_next == CHECK);
      if (take) begin
        case (state)
          HDR0: count_hi <= byte_data;
          HDR1: begin
            count    <= hdr_count;
            byte_idx <= 2'd0;
          end
          DATA: begin
            checksum <= checksum ^ byte_data;
            byte_idx <= byte_idx + 2'd1;
            if (word_last) begin
              // address uses the pre-increment word count; wraps silently
              mem_write_enable <= 1'b1;
              mem_write_data   <= {word_acc, byte_data};
              mem_write_addr   <= ADDR_WIDTH'(BASE_ADDR) + (ADDR_WIDTH'(words_loaded) << 2);
              words_loaded     <= words_loaded + 16'd1;
            end else begin
              word_acc <= {word_acc[15:0], byte_data};
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: good image, bad checksum, oversize and empty headers,
// gapped stream and mid-load reset, with write strobes captured at the falling edge.
module tb_rom_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        mem_write_enable;
  logic [31:0] mem_write_addr;
  logic [31:0] mem_write_data;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  rom_loader dut (
    .clock(clock), .reset(reset),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_write_enable(mem_write_enable), .mem_write_addr(mem_write_addr),
    .mem_write_data(mem_write_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset) begin
      wr_addr.delete();
      wr_data.delete();
    end else if (mem_write_enable) begin
      wr_addr.push_back(mem_write_addr);
      wr_data.push_back(mem_write_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a falling edge; the byte moves on the rising edge in between.
  task automatic send(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
    @(negedge clock);
    byte_valid = 1'b0;
    byte_data  = 8'hxx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
    check({tag, "_we"},    {31'd0, mem_write_enable}, 32'd0);
    check({tag, "_addr"},  mem_write_addr, 32'd0);
    check({tag, "_data"},  mem_write_data, 32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"},  {31'd0, load_done}, 32'd0);
    check({tag, "_err"},   {31'd0, load_error}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic check_good_image(input string tag);
    check({tag, "_nwr"},   wr_addr.size(), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
      check({tag, "_d0"}, wr_data[0], 32'h3C01_0010);
      check({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
      check({tag, "_d1"}, wr_data[1], 32'h0000_0000);
    end
    check({tag, "_done"},  {31'd0, load_done}, 32'd1);
    check({tag, "_err"},   {31'd0, load_error}, 32'd0);
    check({tag, "_hold"},  {31'd0, cpu_hold}, 32'd0);
    check({tag, "_words"}, {16'd0, words_loaded}, 32'd2);
    check({tag, "_ready"}, {31'd0, byte_ready}, 32'd0);
  endtask

  logic [7:0] img[11];

  initial begin
    img = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};

    // reset state
    idle(1);
    check_reset_values("rst");
    reset = 1'b0;
    idle(1);

    // test 1: good two-word image; first strobe visible right after its 4th byte
    for (int i = 0; i < 6; i++) send(img[i]);
    check("t1_strobe0_we",    {31'd0, mem_write_enable}, 32'd1);
    check("t1_strobe0_data",  mem_write_data, 32'h3C01_0010);
    check("t1_strobe0_words", {16'd0, words_loaded}, 32'd1);
    check("t1_mid_hold",      {31'd0, cpu_hold}, 32'd1);
    for (int i = 6; i < 11; i++) send(img[i]);
    idle(2);
    check_good_image("t1");

    // test 2: bad checksum
    do_reset();
    for (int i = 0; i < 10; i++) send(img[i]);
    send(8'h2C);
    idle(2);
    check("t2_err",   {31'd0, load_error}, 32'd1);
    check("t2_done",  {31'd0, load_done}, 32'd0);
    check("t2_hold",  {31'd0, cpu_hold}, 32'd1);
    check("t2_ready", {31'd0, byte_ready}, 32'd0);
    check("t2_nwr",   wr_addr.size(), 32'd2);

    // test 3: oversize count 0x0401 > 1024
    do_reset();
    send(8'h04);
    send(8'h01);
    check("t3_err",   {31'd0, load_error}, 32'd1);
    check("t3_ready", {31'd0, byte_ready}, 32'd0);
    idle(3);
    check("t3_nwr",   wr_addr.size(), 32'd0);
    check("t3_hold",  {31'd0, cpu_hold}, 32'd1);

    // test 3b: count exactly 1024 is accepted into DATA
    do_reset();
    send(8'h04);
    send(8'h00);
    idle(1);
    check("t3b_err",   {31'd0, load_error}, 32'd0);
    check("t3b_ready", {31'd0, byte_ready}, 32'd1);

    // test 4: empty image, good and bad checksum
    do_reset();
    send(8'h00); send(8'h00); send(8'h00);
    idle(1);
    check("t4_done",  {31'd0, load_done}, 32'd1);
    check("t4_hold",  {31'd0, cpu_hold}, 32'd0);
    check("t4_words", {16'd0, words_loaded}, 32'd0);
    check("t4_nwr",   wr_addr.size(), 32'd0);
    do_reset();
    send(8'h00); send(8'h00); send(8'h01);
    idle(1);
    check("t4b_err",  {31'd0, load_error}, 32'd1);
    check("t4b_done", {31'd0, load_done}, 32'd0);

    // test 5: random gaps between bytes
    do_reset();
    for (int i = 0; i < 11; i++) begin
      idle($urandom_range(0, 1));
      send(img[i]);
    end
    idle(2);
    check_good_image("t5");

    // test 6: asynchronous reset after the second payload byte
    do_reset();
    for (int i = 0; i < 4; i++) send(img[i]);
    #2 reset = 1'b1;
    #1 check_reset_values("t6_rst");
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    for (int i = 0; i < 11; i++) send(img[i]);
    idle(2);
    check_good_image("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
